// File: rtl/bit_logic_pkg.sv
// Shared types for the bit logic unit: the op encoding and the accumulation FSM state.
package bit_logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/bit_logic_core.sv
// Purely combinational per-bit logic function f(a,b,op); no carries between bits.
module bit_logic_core
    import bit_logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_ANDN: y_o = a_i & ~b_i;
            OP_PASS: y_o = a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/bit_logic_unit.sv
// Streaming bitwise logic unit with optional multi-beat accumulation and a
// main + skid output stage so in_ready never depends combinationally on out_ready.
module bit_logic_unit
    import bit_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             last,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             all_ones,
    output logic [CNTW-1:0]  beats
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNTW-1:0]  cnt_q;

    logic [WIDTH-1:0] out_q, out_d, skidData_q, skidData_d;
    logic             zero_q, zero_d, skidZero_q, skidZero_d;
    logic             ones_q, ones_d, skidOnes_q, skidOnes_d;
    logic [CNTW-1:0]  beats_q, beats_d, skidBeats_q, skidBeats_d;
    logic             outValid_q, outValid_d, skidValid_q, skidValid_d;
    logic             inReady_q;

    logic             accept, consume, produce;
    logic [WIDTH-1:0] coreA, coreY;
    logic [CNTW-1:0]  cntInc, resBeats;

    assign accept  = in_valid && inReady_q;
    assign consume = outValid_q && out_ready;
    assign coreA   = (state_q == ST_ACCUM) ? acc_q : in0;
    assign cntInc  = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    bit_logic_core #(.WIDTH(WIDTH)) u_core (
        .a_i  (coreA),
        .b_i  (in1),
        .op_i (op_e'(op)),
        .y_o  (coreY)
    );

    always_comb begin
        produce  = 1'b0;
        resBeats = CNTW'(1);
        if (accept) begin
            if (state_q == ST_IDLE) begin
                produce = !acc_en || last;
            end else begin
                produce  = last;
                resBeats = cntInc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (acc_en && !last) begin
                        acc_q   <= coreY;
                        cnt_q   <= CNTW'(1);
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= coreY;
                        cnt_q <= cntInc;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A full skid blocks input, so a produce can only coincide with an empty skid.
    always_comb begin
        out_d       = out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        beats_d     = beats_q;
        outValid_d  = outValid_q;
        skidData_d  = skidData_q;
        skidZero_d  = skidZero_q;
        skidOnes_d  = skidOnes_q;
        skidBeats_d = skidBeats_q;
        skidValid_d = skidValid_q;
        if (skidValid_q) begin
            if (consume) begin
                out_d       = skidData_q;
                zero_d      = skidZero_q;
                ones_d      = skidOnes_q;
                beats_d     = skidBeats_q;
                skidValid_d = 1'b0;
            end
        end else if (produce) begin
            if (!outValid_q || consume) begin
                out_d      = coreY;
                zero_d     = (coreY == '0);
                ones_d     = (coreY == {WIDTH{1'b1}});
                beats_d    = resBeats;
                outValid_d = 1'b1;
            end else begin
                skidData_d  = coreY;
                skidZero_d  = (coreY == '0);
                skidOnes_d  = (coreY == {WIDTH{1'b1}});
                skidBeats_d = resBeats;
                skidValid_d = 1'b1;
            end
        end else if (consume) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            beats_q     <= '0;
            outValid_q  <= 1'b0;
            skidData_q  <= '0;
            skidZero_q  <= 1'b0;
            skidOnes_q  <= 1'b0;
            skidBeats_q <= '0;
            skidValid_q <= 1'b0;
            inReady_q   <= 1'b1;
        end else begin
            out_q       <= out_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            beats_q     <= beats_d;
            outValid_q  <= outValid_d;
            skidData_q  <= skidData_d;
            skidZero_q  <= skidZero_d;
            skidOnes_q  <= skidOnes_d;
            skidBeats_q <= skidBeats_d;
            skidValid_q <= skidValid_d;
            inReady_q   <= !skidValid_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign all_ones  = ones_q;
    assign beats     = beats_q;

endmodule

// File: doc/bit_logic_unit.md
BIT_LOGIC_UNIT -- requirements
Module: bit_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width; legal values are 1 to 128.
REQ-002 The block SHALL have parameter CNTW, default 8, which sets the width of the beat counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk: input, 1 bit, the single rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in_valid: input, 1 bit, an input beat is presented.
REQ-007 Port in_ready: output, 1 bit, the block can accept a beat.
REQ-008 Port op: input, 3 bits, operation select for the beat.
REQ-009 Port acc_en: input, 1 bit, the beat opens a multi-beat accumulation.
REQ-010 Port last: input, 1 bit, the beat closes an accumulation.
REQ-011 Port in0: input, WIDTH bits, operand A.
REQ-012 Port in1: input, WIDTH bits, operand B.
REQ-013 Port out_valid: output, 1 bit, a result is presented.
REQ-014 Port out_ready: input, 1 bit, downstream accepts the result.
REQ-015 Port out: output, WIDTH bits, the result.
REQ-016 Port zero: output, 1 bit, asserted when out is all zeros.
REQ-017 Port all_ones: output, 1 bit, asserted when out is all ones.
REQ-018 Port beats: output, CNTW bits, number of input beats folded into out.

Function
REQ-019 A beat SHALL be accepted exactly when in_valid && in_ready at a rising clk edge; a result SHALL be consumed exactly when out_valid && out_ready.
REQ-020 The op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS (a).
REQ-021 The function f(a,b,op) SHALL be applied bitwise, independently per bit, with no carries.
REQ-022 The state machine SHALL have two states, IDLE and ACCUM.
REQ-023 In IDLE, an accepted beat with acc_en=0, or with acc_en=1 and last=1, SHALL produce the result f(in0,in1,op) with beats=1.
REQ-024 In IDLE, an accepted beat with acc_en=1 and last=0 SHALL load acc<=f(in0,in1,op) and cnt<=1, move to ACCUM, and produce no result.
REQ-025 In ACCUM, an accepted beat SHALL compute f(acc,in1,op) using that beat's op; in0 and acc_en are ignored.
REQ-026 In ACCUM with last=0, the beat SHALL update acc and increment cnt; cnt saturates at 2^CNTW-1.
REQ-027 In ACCUM with last=1, the beat SHALL produce f(acc,in1,op) with beats=cnt+1 (saturating) and return to IDLE.
REQ-028 Result latency SHALL be 1 cycle: a result is visible on out the cycle after its producing beat is accepted, provided the output stage is empty or being consumed.
REQ-029 The output stage SHALL be a main register plus a one-entry skid register.
REQ-030 in_ready SHALL equal !skid_valid and be driven from a register, with no combinational path from out_ready.
REQ-031 While out_valid=1 and out_ready=0, out, zero, all_ones and beats SHALL be held stable.
REQ-032 When a result is produced while the main register is held, the result SHALL go to skid; skid drains to the main register on the next consume.
REQ-033 A produce and a consume in the same cycle SHALL be handled without a bubble or data loss.
REQ-034 Beats that only update acc SHALL be accepted whenever in_ready=1, regardless of output occupancy.
REQ-035 zero and all_ones SHALL be registered alongside out and be valid only when out_valid=1.

Reset
REQ-036 While rst_n=0, the block SHALL be forced to: state IDLE, acc=0, cnt=0, out=0, beats=0, zero=0, all_ones=0, out_valid=0, skid_valid=0, in_ready=1.
REQ-037 Reset asserted mid-accumulation or with results pending SHALL discard all of them; no partial result is emitted after deassertion.

Structure
REQ-038 Package bit_logic_pkg SHALL hold the op encoding constants/enum and the state type.
REQ-039 Sub-module bit_logic_core SHALL be purely combinational, compute f(a,b,op) for parameter WIDTH, and be instantiated once, with its a input muxed between in0 and acc.

Verification
REQ-040 Reset, then send one beat op=0, in0=FFFF0000, in1=0F0F0F0F, acc_en=0 -> out=0F0F0000, beats=1, zero=0, one cycle after acceptance.
REQ-041 Send op=2, in0=in1=12345678 -> out=0, zero=1; then op=4, in0=in1=0 -> out=FFFFFFFF, all_ones=1.
REQ-042 Send accumulation beats: (acc_en=1, op=1, in0=1, in1=2), then (op=1, in1=4), then (op=0, in1=6, last=1) -> one result, out=6, beats=3.
REQ-043 Hold out_ready=0 and send two single beats 1 and 2 -> out holds 1, in_ready falls to 0; then release out_ready -> results 1 then 2, in order, none lost.
REQ-044 Assert rst_n=0 after two beats of an accumulation, then deassert and send a single beat op=7, in0=A5 -> only out=A5 appears, beats=1.
REQ-045 With CNTW=2, send a 5-beat accumulation -> beats=3 (saturated).
